multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath with stretchable memory states.
// Optional ADDI support is compiled in when MC_ADDI_EN is defined.
module multicycle_control #(
    parameter int MEM_WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       alusrca,
    output logic       regdst,
    output logic       memtoreg,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_e;

    typedef struct packed {
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       regwrite;
        logic       memwrite;
        logic       iord;
        logic       alusrca;
        logic       regdst;
        logic       memtoreg;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_CYCLES);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wait_done_s;
    ctrl_t      ctrl_s;
    ctrl_t      ctrl_out_s;

    assign wait_done_s = (cnt_q == WAIT_LAST);

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter only runs in the held memory states and is zero elsewhere.
    always_comb begin
        state_d = FETCH;
        cnt_d   = 4'd0;
        case (state_q)
            FETCH: begin
                if (wait_done_s) begin
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = ADDIEX;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (op == OP_SW) begin
                    state_d = MEMWR;
                end else begin
                    state_d = MEMRD;
                end
            end
            MEMRD: begin
                if (wait_done_s) begin
                    state_d = MEMWB;
                end else begin
                    state_d = MEMRD;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            MEMWR: begin
                if (wait_done_s) begin
                    state_d = FETCH;
                end else begin
                    state_d = MEMWR;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            RTYPEEX: state_d = RTYPEWB;
`ifdef MC_ADDI_EN
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
`endif
            MEMWB, RTYPEWB, BEQEX, JEX: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Per-state control decode; FETCH strobes fire only on the last cycle of the hold.
    always_comb begin
        ctrl_s = '0;
        case (state_q)
            FETCH: begin
                ctrl_s.alusrcb = 2'b01;
                ctrl_s.irwrite = wait_done_s;
                ctrl_s.pcwrite = wait_done_s;
            end
            DECODE:  ctrl_s.alusrcb = 2'b11;
            MEMADR: begin
                ctrl_s.alusrca = 1'b1;
                ctrl_s.alusrcb = 2'b10;
            end
            MEMRD:   ctrl_s.iord = 1'b1;
            MEMWB: begin
                ctrl_s.memtoreg = 1'b1;
                ctrl_s.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl_s.iord     = 1'b1;
                ctrl_s.memwrite = 1'b1;
            end
            RTYPEEX: begin
                ctrl_s.alusrca = 1'b1;
                ctrl_s.aluop   = 2'b10;
            end
            RTYPEWB: begin
                ctrl_s.regdst   = 1'b1;
                ctrl_s.regwrite = 1'b1;
            end
            BEQEX: begin
                ctrl_s.alusrca = 1'b1;
                ctrl_s.aluop   = 2'b01;
                ctrl_s.pcsrc   = 2'b01;
                ctrl_s.branch  = 1'b1;
            end
`ifdef MC_ADDI_EN
            ADDIEX: begin
                ctrl_s.alusrca = 1'b1;
                ctrl_s.alusrcb = 2'b10;
            end
            ADDIWB:  ctrl_s.regwrite = 1'b1;
`endif
            JEX: begin
                ctrl_s.pcsrc   = 2'b10;
                ctrl_s.pcwrite = 1'b1;
            end
            default: ctrl_s = '0;
        endcase
    end

    // The reset state is FETCH, whose strobes must stay quiet while rst_n is held low.
    assign ctrl_out_s = rst_n ? ctrl_s : '0;

    assign irwrite  = ctrl_out_s.irwrite;
    assign pcwrite  = ctrl_out_s.pcwrite;
    assign branch   = ctrl_out_s.branch;
    assign regwrite = ctrl_out_s.regwrite;
    assign memwrite = ctrl_out_s.memwrite;
    assign iord     = ctrl_out_s.iord;
    assign alusrca  = ctrl_out_s.alusrca;
    assign regdst   = ctrl_out_s.regdst;
    assign memtoreg = ctrl_out_s.memtoreg;
    assign alusrcb  = ctrl_out_s.alusrcb;
    assign pcsrc    = ctrl_out_s.pcsrc;
    assign aluop    = ctrl_out_s.aluop;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: wait-0 instance for state/output traces,
// wait-2 instance for stretched FETCH and MEMWR.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;

    logic       w0_irwrite, w0_pcwrite, w0_branch, w0_regwrite, w0_memwrite;
    logic       w0_iord, w0_alusrca, w0_regdst, w0_memtoreg;
    logic [1:0] w0_alusrcb, w0_pcsrc, w0_aluop;
    logic [3:0] w0_state;
    logic       w2_irwrite, w2_pcwrite, w2_branch, w2_regwrite, w2_memwrite;
    logic       w2_iord, w2_alusrca, w2_regdst, w2_memtoreg;
    logic [1:0] w2_alusrcb, w2_pcsrc, w2_aluop;
    logic [3:0] w2_state;
    logic [14:0] outs0, outs2;

    int n_pass = 0;
    int n_chk  = 0;

    multicycle_control #(.MEM_WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .op(op),
        .irwrite(w0_irwrite), .pcwrite(w0_pcwrite), .branch(w0_branch),
        .regwrite(w0_regwrite), .memwrite(w0_memwrite), .iord(w0_iord),
        .alusrca(w0_alusrca), .regdst(w0_regdst), .memtoreg(w0_memtoreg),
        .alusrcb(w0_alusrcb), .pcsrc(w0_pcsrc), .aluop(w0_aluop), .state(w0_state)
    );

    multicycle_control #(.MEM_WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .op(op),
        .irwrite(w2_irwrite), .pcwrite(w2_pcwrite), .branch(w2_branch),
        .regwrite(w2_regwrite), .memwrite(w2_memwrite), .iord(w2_iord),
        .alusrca(w2_alusrca), .regdst(w2_regdst), .memtoreg(w2_memtoreg),
        .alusrcb(w2_alusrcb), .pcsrc(w2_pcsrc), .aluop(w2_aluop), .state(w2_state)
    );

    // Order: irwrite,pcwrite,branch,regwrite,memwrite,iord,alusrca,regdst,memtoreg,alusrcb,pcsrc,aluop
    assign outs0 = {w0_irwrite, w0_pcwrite, w0_branch, w0_regwrite, w0_memwrite, w0_iord,
                    w0_alusrca, w0_regdst, w0_memtoreg, w0_alusrcb, w0_pcsrc, w0_aluop};
    assign outs2 = {w2_irwrite, w2_pcwrite, w2_branch, w2_regwrite, w2_memwrite, w2_iord,
                    w2_alusrca, w2_regdst, w2_memtoreg, w2_alusrcb, w2_pcsrc, w2_aluop};

    always #5 clk = ~clk;

    // Hand-written output table for MEM_WAIT_CYCLES=0.
    function automatic logic [14:0] exp_outs(input logic [3:0] s);
        case (s)
            4'd0:    return {9'b110000000, 2'b01, 2'b00, 2'b00};
            4'd1:    return {9'b000000000, 2'b11, 2'b00, 2'b00};
            4'd2:    return {9'b000000100, 2'b10, 2'b00, 2'b00};
            4'd3:    return {9'b000001000, 2'b00, 2'b00, 2'b00};
            4'd4:    return {9'b000100001, 2'b00, 2'b00, 2'b00};
            4'd5:    return {9'b000011000, 2'b00, 2'b00, 2'b00};
            4'd6:    return {9'b000000100, 2'b00, 2'b00, 2'b10};
            4'd7:    return {9'b000100010, 2'b00, 2'b00, 2'b00};
            4'd8:    return {9'b001000100, 2'b00, 2'b01, 2'b01};
            4'd9:    return {9'b000000100, 2'b10, 2'b00, 2'b00};
            4'd10:   return {9'b000100000, 2'b00, 2'b00, 2'b00};
            4'd11:   return {9'b010000000, 2'b00, 2'b10, 2'b00};
            default: return 15'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [5:0] opc);
        rst_n = 1'b0;
        op    = opc;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // seq holds one expected state per nibble, cycle 0 in the low nibble.
    task automatic run_seq(input string tag, input logic [5:0] opc, input logic [5:0] op_late,
                           input int n, input logic [63:0] seq);
        logic [3:0] es;
        do_reset(opc);
        for (int i = 0; i < n; i++) begin
            es = seq[i*4 +: 4];
            chk($sformatf("%s[%0d] state", tag, i), {28'd0, w0_state}, {28'd0, es});
            chk($sformatf("%s[%0d] outs", tag, i), {17'd0, outs0}, {17'd0, exp_outs(es)});
            if (i == 3) op = op_late;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst state0", {28'd0, w0_state}, 32'd0);
        chk("rst outs0", {17'd0, outs0}, 32'd0);
        chk("rst state2", {28'd0, w2_state}, 32'd0);
        chk("rst outs2", {17'd0, outs2}, 32'd0);

        run_seq("lw",    6'b100011, 6'b101011, 6, 64'h043210);
        run_seq("sw",    6'b101011, 6'b100011, 5, 64'h05210);
        run_seq("rtype", 6'b000000, 6'b000100, 5, 64'h07610);
        run_seq("beq",   6'b000100, 6'b000000, 4, 64'h0810);
        run_seq("j",     6'b000010, 6'b000000, 4, 64'h0B10);
        run_seq("unk",   6'b111111, 6'b000000, 3, 64'h010);
`ifdef MC_ADDI_EN
        run_seq("addi",  6'b001000, 6'b000000, 5, 64'h0A910);
`else
        run_seq("addi",  6'b001000, 6'b000000, 3, 64'h010);
`endif

        // Reset asserted in RTYPEEX, then released.
        do_reset(6'b000000);
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        chk("mid pre state", {28'd0, w0_state}, 32'd6);
        chk("mid pre outs", {17'd0, outs0}, {17'd0, exp_outs(4'd6)});
        rst_n = 1'b0;
        #1;
        chk("mid rst state", {28'd0, w0_state}, 32'd0);
        chk("mid rst outs", {17'd0, outs0}, 32'd0);
        @(negedge clk);
        #1;
        chk("mid hold outs", {17'd0, outs0}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mid rel state", {28'd0, w0_state}, 32'd0);
        chk("mid rel outs", {17'd0, outs0}, {17'd0, exp_outs(4'd0)});
        @(negedge clk);
        #1;
        chk("mid next state", {28'd0, w0_state}, 32'd1);

        // MEM_WAIT_CYCLES=2 store: FETCH x3, DECODE, MEMADR, MEMWR x3, FETCH.
        do_reset(6'b101011);
        for (int i = 0; i < 9; i++) begin
            logic [63:0] seq2;
            logic [3:0]  es2;
            logic        in_wr;
            seq2  = 64'h055521000;
            es2   = seq2[i*4 +: 4];
            in_wr = (i >= 5) && (i <= 7);
            chk($sformatf("w2[%0d] state", i), {28'd0, w2_state}, {28'd0, es2});
            chk($sformatf("w2[%0d] irwrite", i), {31'd0, w2_irwrite}, {31'd0, (i == 2)});
            chk($sformatf("w2[%0d] pcwrite", i), {31'd0, w2_pcwrite}, {31'd0, (i == 2)});
            chk($sformatf("w2[%0d] memwrite", i), {31'd0, w2_memwrite}, {31'd0, in_wr});
            chk($sformatf("w2[%0d] iord", i), {31'd0, w2_iord}, {31'd0, in_wr});
            @(negedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
